// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the arbiter's three buses. Instruction fetch: if_req, if_addr,
//   if_flush, if_gnt and if_rvalid. Load/store: ls_req, ls_we, ls_addr,
//   ls_wdata, ls_gnt and ls_rvalid. Memory: mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready, mem_rvalid and mem_rdata. rdata is the response
//   data shared by both requesters.
//   Modports:
//     slave  - the arbiter's view (drives gnt/rvalid/rdata and mem_* requests)
//     master - the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  // Instruction-fetch port
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_flush;
  logic            if_gnt;
  logic            if_rvalid;
  // Load/store port
  logic            ls_req;
  logic            ls_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic            ls_gnt;
  logic            ls_rvalid;
  // Shared response data
  logic [XLEN-1:0] rdata;
  // Memory port
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. Only one transaction is outstanding at a time:
//   IDLE (grant) -> ISSUE (mem_req until mem_ready) -> RESP (wait for
//   mem_rvalid) -> IDLE. The response is registered into rdata and announced
//   with a one-cycle rvalid pulse to the owner. if_flush discards a pending
//   fetch response without disturbing the memory transaction.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - mem_port_arbiter_if.slave (fetch, load/store and memory buses)
//   Configuration:
//     ARB_ROUND_ROBIN_EN - when defined, contention is resolved round-robin
//                          (the requester not granted last wins); otherwise
//                          load/store has fixed priority over fetch.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {OWNER_IF = 1'b0, OWNER_LS = 1'b1} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            drop_q, drop_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            ls_rvalid_q, ls_rvalid_d;

  logic if_elig, ls_elig, if_win, ls_win, flush_hit;

  // A flushed fetch may not win in the same cycle.
  assign if_elig   = bus.if_req & ~bus.if_flush;
  assign ls_elig   = bus.ls_req;
  assign flush_hit = bus.if_flush & (owner_q == OWNER_IF);

`ifdef ARB_ROUND_ROBIN_EN
  // last_q remembers the most recent winner; it resets to IF so LS wins the
  // first contention.
  owner_e last_q, last_d;

  always_comb begin
    if (if_elig && ls_elig) begin
      ls_win = (last_q == OWNER_IF);
      if_win = ~ls_win;
    end else begin
      ls_win = ls_elig;
      if_win = if_elig;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE) begin
      if (ls_win)      last_d = OWNER_LS;
      else if (if_win) last_d = OWNER_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWNER_IF;
    else        last_q <= last_d;
  end
`else
  assign ls_win = ls_elig;
  assign if_win = if_elig & ~ls_elig;
`endif

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    drop_d      = drop_q;
    rdata_d     = rdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (ls_win) begin
          owner_d = OWNER_LS;
          addr_d  = bus.ls_addr;
          we_d    = bus.ls_we;
          wdata_d = bus.ls_wdata;
          state_d = ISSUE;
        end else if (if_win) begin
          // Fetches are always reads with zero write data.
          owner_d = OWNER_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (flush_hit)     drop_d  = 1'b1;
        if (bus.mem_ready) state_d = RESP;
      end

      RESP: begin
        if (flush_hit) drop_d = 1'b1;
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWNER_LS) begin
            rdata_d     = bus.mem_rdata;
            ls_rvalid_d = 1'b1;
          end else if (!(drop_q || bus.if_flush)) begin
            // A flush in this very cycle suppresses the response as well.
            rdata_d     = bus.mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because every output,
  // rdata and the mem_* fields included, must read 0 while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drop_q      <= 1'b0;
      rdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      drop_q      <= drop_d;
      rdata_q     <= rdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  // Grants are combinational. They are masked by rst_n so that a request
  // held during reset does not show a grant.
  assign bus.if_gnt    = rst_n & (state_q == IDLE) & if_win;
  assign bus.ls_gnt    = rst_n & (state_q == IDLE) & ls_win;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Each accepted request pushes its
//   expected response (owner, data, arrival cycle) into a queue. A monitor
//   pops one entry and compares it whenever if_rvalid or ls_rvalid pulses.
//   The memory side is a small responder with programmable ready and
//   response delays. A manual mode lets the reset test drive mem_* directly.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_ls;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input bit is_ls, input logic [31:0] data, input int cyc);
    exp_t e;
    e.is_ls = is_ls;
    e.data  = data;
    e.cyc   = cyc;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid || bus.ls_rvalid) begin
        check("rvalid_excl", {31'b0, bus.if_rvalid & bus.ls_rvalid}, 32'd0);
        if (sb_q.size() == 0) begin
          check("rvalid_unexpected", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rvalid_owner_ls", {31'b0, bus.ls_rvalid}, {31'b0, e.is_ls});
          check("rvalid_rdata", bus.rdata, e.data);
          check("rvalid_cycle", cyc_cnt, e.cyc);
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  bit          mem_en;
  int          ready_wait;
  int          rvalid_wait;
  logic [31:0] resp_data;
  logic        mdl_ready, mdl_rvalid;
  logic [31:0] mdl_rdata;
  logic        man_ready, man_rvalid;
  logic [31:0] man_rdata;

  assign bus.mem_ready  = mem_en ? mdl_ready  : man_ready;
  assign bus.mem_rvalid = mem_en ? mdl_rvalid : man_rvalid;
  assign bus.mem_rdata  = mem_en ? mdl_rdata  : man_rdata;

  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    mdl_ready = 1'b0;
    mdl_rvalid = 1'b0;
    mdl_rdata = '0;
    forever begin
      @(negedge clk);
      mdl_ready  = 1'b0;
      mdl_rvalid = 1'b0;
      if (!rst_n || !mem_en) begin
        ph = 0;
        cnt = 0;
      end else if (ph == 0) begin
        if (bus.mem_req) begin
          if (cnt == ready_wait) begin
            mdl_ready = 1'b1;
            ph = 1;
            cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt == rvalid_wait) begin
          mdl_rvalid = 1'b1;
          mdl_rdata  = resp_data;
          ph = 0;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_gnt"},    {31'b0, bus.if_gnt},    32'd0);
    check({tag, "_ls_gnt"},    {31'b0, bus.ls_gnt},    32'd0);
    check({tag, "_if_rvalid"}, {31'b0, bus.if_rvalid}, 32'd0);
    check({tag, "_ls_rvalid"}, {31'b0, bus.ls_rvalid}, 32'd0);
    check({tag, "_mem_req"},   {31'b0, bus.mem_req},   32'd0);
    check({tag, "_mem_we"},    {31'b0, bus.mem_we},    32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,           32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,          32'd0);
    check({tag, "_rdata"},     bus.rdata,              32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_cnt);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    int  n_req;
    int  n_gnt;
    bit  exp_ls [4];

`ifdef ARB_ROUND_ROBIN_EN
    exp_ls = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    rst_n        = 1'b0;
    mem_en       = 1'b1;
    ready_wait   = 0;
    rvalid_wait  = 0;
    resp_data    = '0;
    man_ready    = 1'b0;
    man_rvalid   = 1'b0;
    man_rdata    = '0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;

    // Reset with both requests asserted: no output may be non-zero.
    #3;
    bus.if_req   = 1'b1;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.if_addr  = 32'h100;
    bus.ls_addr  = 32'h200;
    bus.ls_wdata = 32'h55;
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch: grant at 0, mem_req at 1, if_rvalid at 3.
    step();
    resp_data   = 32'hDEADBEEF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge clk);
    check("t1_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    check("t1_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);
    push(1'b0, 32'hDEADBEEF, cyc_cnt + 3);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t1_mem_req",   {31'b0, bus.mem_req}, 32'd1);
    check("t1_mem_addr",  bus.mem_addr,         32'h100);
    check("t1_mem_we",    {31'b0, bus.mem_we},  32'd0);
    drain();

    // Store with mem_ready low for 4 cycles: 5 cycles of mem_req.
    step();
    ready_wait   = 4;
    resp_data    = 32'h0000_1234;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h2000;
    bus.ls_wdata = 32'h55;
    @(negedge clk);
    check("t2_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    check("t2_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    push(1'b1, 32'h0000_1234, cyc_cnt + 7);
    step();
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_wdata = '0;
    n_req = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        n_req++;
        check("t2_mem_we",    {31'b0, bus.mem_we}, 32'd1);
        check("t2_mem_wdata", bus.mem_wdata,       32'h55);
        check("t2_mem_addr",  bus.mem_addr,        32'h2000);
      end
    end
    check("t2_req_cycles", n_req, 32'd5);
    drain();

    // Contention from reset: both requests held for four grants.
    do_reset();
    step();
    ready_wait  = 0;
    rvalid_wait = 0;
    resp_data   = 32'h0BAD_F00D;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h400;
    n_gnt = 0;
    n = 0;
    while (n_gnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.if_gnt || bus.ls_gnt) begin
        check("t3_gnt_excl",  {31'b0, bus.if_gnt & bus.ls_gnt}, 32'd0);
        check("t3_gnt_order", {31'b0, bus.ls_gnt}, {31'b0, exp_ls[n_gnt]});
        push(exp_ls[n_gnt], 32'h0BAD_F00D, cyc_cnt + 3);
        n_gnt++;
        if (n_gnt == 4) begin
          step();
          bus.if_req = 1'b0;
          bus.ls_req = 1'b0;
        end
      end
    end
    check("t3_gnt_count", n_gnt, 32'd4);
    drain();

    // Flush during RESP, mem_rvalid two cycles later: response dropped.
    step();
    rvalid_wait = 2;
    resp_data   = 32'hCAFE_0001;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    @(negedge clk);
    check("t4_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t4_mem_req",   {31'b0, bus.mem_req}, 32'd1);
    check("t4_mem_we",    {31'b0, bus.mem_we},  32'd0);
    check("t4_mem_wdata", bus.mem_wdata,        32'd0);
    check("t4_mem_addr",  bus.mem_addr,         32'h500);
    step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    check("t4_rdata",     bus.rdata,              32'h0BAD_F00D);
    // The next fetch is granted at once and is delivered (drop flag cleared).
    step();
    rvalid_wait = 0;
    resp_data   = 32'h1111_2222;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h600;
    @(negedge clk);
    check("t4_next_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    push(1'b0, 32'h1111_2222, cyc_cnt + 3);
    step();
    bus.if_req = 1'b0;
    drain();

    // Flush coincident with mem_rvalid suppresses that response.
    step();
    resp_data   = 32'h3333_4444;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h700;
    @(negedge clk);
    check("t5_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    step();
    bus.if_req = 1'b0;
    step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    @(negedge clk);
    check("t5_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    check("t5_rdata",     bus.rdata,              32'h1111_2222);
    // Flush in IDLE blocks IF only; LS wins and is unaffected by the flush.
    step();
    bus.if_req   = 1'b1;
    bus.if_flush = 1'b1;
    bus.if_addr  = 32'h800;
    @(negedge clk);
    check("t5_flush_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    check("t5_flush_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);
    step();
    resp_data    = 32'h5555_6666;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h900;
    bus.ls_wdata = 32'hA5;
    @(negedge clk);
    check("t5_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    check("t5_if_gnt_blocked", {31'b0, bus.if_gnt}, 32'd0);
    push(1'b1, 32'h5555_6666, cyc_cnt + 3);
    step();
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    bus.if_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.if_flush = 1'b0;
    drain();

    // Reset in ISSUE; a stray mem_rvalid afterwards is ignored.
    step();
    mem_en      = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hA00;
    @(negedge clk);
    check("t6_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    @(negedge clk);
    check("t6_mem_req", {31'b0, bus.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    bus.if_req = 1'b0;
    rst_n = 1'b1;
    step();
    man_rvalid = 1'b1;
    man_rdata  = 32'hBAD0_BAD0;
    step();
    man_rvalid = 1'b0;
    @(negedge clk);
    check("t6_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    check("t6_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
    check("t6_rdata",     bus.rdata,              32'd0);
    step();
    mem_en      = 1'b1;
    resp_data   = 32'h7777_8888;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hB00;
    @(negedge clk);
    check("t6_new_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    push(1'b0, 32'h7777_8888, cyc_cnt + 3);
    step();
    bus.if_req = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
